// File: rtl/cfi_log_queue.sv
// cfi_log_queue: two-port in-order log FIFO between the commit stage and
// cfi_backend. The commit stage pushes up to two cfi_log_t records per cycle
// and the backend reads the head and pops it once its doorbell completes.
// Optional feature: define CFI_LOG_QUEUE_STATS_EN to build the high-water
// occupancy register; otherwise high_water_o is tied to zero.

package cfi_pkg;

  // 256-bit CFI log record handed to the backend in eight 32-bit beats.
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] target;
    logic [31:0] insn;
    logic [7:0]  kind;
    logic [87:0] meta;
  } cfi_log_t;

endpackage

module cfi_log_queue
  import cfi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [1:0]                 push_valid_i,
  input  cfi_log_t [1:0]             push_log_i,
  output logic [1:0]                 push_ready_o,
  input  logic                       pop_i,
  output cfi_log_t                   log_o,
  output logic                       queue_empty_o,
  output logic                       queue_full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     high_water_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ROOM1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ROOM2 = CW'(DEPTH - 2);

  cfi_log_t        mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic [1:0]      ready;
  logic            acc0;
  logic            acc1;
  logic [CW-1:0]   num_acc;
  logic            pop_eff;
  logic [AW-1:0]   wr_addr1;
  logic [CW-1:0]   count_next;

  // Accept logic: readiness depends only on registered count and port-0 valid,
  // so a same-cycle pop never opens space and there is no path from pop_i.
  always_comb begin
    ready[0] = (count <= CNT_ROOM1);
    ready[1] = push_valid_i[0] ? (count <= CNT_ROOM2) : (count <= CNT_ROOM1);
    acc0     = push_valid_i[0] & ready[0];
    // Port 1 is younger; it only goes in if port 0 goes in or is idle.
    acc1     = push_valid_i[1] & ready[1] & (acc0 | ~push_valid_i[0]);
    num_acc  = CW'(acc0) + CW'(acc1);
    pop_eff  = pop_i & (count != '0);
    wr_addr1 = acc0 ? wr_ptr + AW'(1) : wr_ptr;
    if (flush_i) begin
      count_next = '0;
    end else begin
      count_next = count + num_acc - CW'(pop_eff);
    end
  end

  // Record storage: written in program order at wr_ptr / wr_ptr+1.
  // NOTE: storage has no reset; only pointers and count define validity, and
  // resetting a wide register file would cost a reset tree for no benefit.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (acc0) begin
        mem[wr_ptr] <= push_log_i[0];
      end
      if (acc1) begin
        mem[wr_addr1] <= push_log_i[1];
      end
    end
  end

  // Pointer and occupancy state; flush wins over push and pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(num_acc);
      if (pop_eff) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
    end
  end

`ifdef CFI_LOG_QUEUE_STATS_EN
  logic [CW-1:0] high_water;

  // Peak occupancy since reset or flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      high_water <= '0;
    end else if (flush_i) begin
      high_water <= '0;
    end else if (count_next > high_water) begin
      high_water <= count_next;
    end
  end

  assign high_water_o = high_water;
`else
  assign high_water_o = '0;
`endif

  // Head and status outputs, all derived from registered state.
  assign log_o         = (count != '0) ? mem[rd_ptr] : '0;
  assign push_ready_o  = ready;
  assign queue_empty_o = (count == '0);
  assign queue_full_o  = (count == CNT_FULL);
  assign count_o       = count;

endmodule

// File: tb/tb_cfi_log_queue.sv
// Bench for cfi_log_queue: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_cfi_log_queue;
  import cfi_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef CFI_LOG_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [1:0]     push_valid;
  cfi_log_t [1:0] push_log;
  logic [1:0]     push_ready;
  logic           pop;
  cfi_log_t       log_q;
  logic           queue_empty;
  logic           queue_full;
  logic [CW-1:0]  count;
  logic [CW-1:0]  high_water;

  int tests = 0;
  int fails = 0;

  cfi_log_queue #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .push_valid_i (push_valid),
    .push_log_i   (push_log),
    .push_ready_o (push_ready),
    .pop_i        (pop),
    .log_o        (log_q),
    .queue_empty_o(queue_empty),
    .queue_full_o (queue_full),
    .count_o      (count),
    .high_water_o (high_water)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cfi_log_t mk(input int k);
    cfi_log_t r;
    r = {8{32'hA5A5_0000 + 32'(k)}};
    return r;
  endfunction

  // ---------------- reference model: plain queue of records ----------------
  cfi_log_t mq[$];
  int       mhw = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mhw = 0;
    end else if (flush) begin
      mq.delete();
      mhw = 0;
    end else begin
      int  n;
      bit  r0, r1, a0, a1;
      n  = mq.size();
      r0 = n < DEPTH;
      r1 = push_valid[0] ? (n <= DEPTH - 2) : (n < DEPTH);
      a0 = push_valid[0] && r0;
      a1 = push_valid[1] && r1 && (a0 || !push_valid[0]);
      if (pop && n > 0) void'(mq.pop_front());
      if (a0) mq.push_back(push_log[0]);
      if (a1) mq.push_back(push_log[1]);
      if (mq.size() > mhw) mhw = mq.size();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      int n;
      logic [1:0] er;
      n     = mq.size();
      er[0] = n < DEPTH;
      er[1] = push_valid[0] ? (n <= DEPTH - 2) : (n < DEPTH);
      check("m_count", 256'(count), 256'(n));
      check("m_empty", 256'(queue_empty), 256'(n == 0));
      check("m_full",  256'(queue_full), 256'(n == DEPTH));
      check("m_ready", 256'(push_ready), 256'(er));
      check("m_head",  256'(log_q), (n > 0) ? 256'(mq[0]) : 256'(0));
      check("m_hwater", 256'(high_water), STATS ? 256'(mhw) : 256'(0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic [1:0] v, input cfi_log_t l0, input cfi_log_t l1,
                        input logic p, input logic f);
    push_valid  = v;
    push_log[0] = l0;
    push_log[1] = l1;
    pop         = p;
    flush       = f;
  endtask

  task automatic idle();
    set_in(2'b00, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  cfi_log_t held;

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_count", 256'(count), 256'(0));
    check("rst_empty", 256'(queue_empty), 256'(1));
    check("rst_full",  256'(queue_full), 256'(0));
    check("rst_ready", 256'(push_ready), 256'(2'b11));
    check("rst_log",   256'(log_q), 256'(0));
    check("rst_hw",    256'(high_water), 256'(0));

    // Single record A on port 0.
    set_in(2'b01, mk(1), '0, 1'b0, 1'b0);
    #1 check("single_ready", 256'(push_ready), 256'(2'b11));
    tick(); idle();
    #1;
    check("single_log",   256'(log_q), 256'(mk(1)));
    check("single_count", 256'(count), 256'(1));
    check("single_empty", 256'(queue_empty), 256'(0));
    set_in(2'b00, '0, '0, 1'b1, 1'b0);
    tick(); idle();
    #1;
    check("single_pop_empty", 256'(queue_empty), 256'(1));
    check("single_pop_log",   256'(log_q), 256'(0));

    // Dual pushes to full, then drain in order; done twice for wrap-around.
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 4; i++) begin
        set_in(2'b11, mk(10 * rep + 2 * i), mk(10 * rep + 2 * i + 1), 1'b0, 1'b0);
        tick();
      end
      set_in(2'b11, mk(99), mk(98), 1'b0, 1'b0);
      #1;
      check("dual_full",  256'(queue_full), 256'(1));
      check("dual_ready", 256'(push_ready), 256'(2'b00));
      tick();
      for (int i = 0; i < 8; i++) begin
        set_in(2'b00, '0, '0, 1'b1, 1'b0);
        #1 check("dual_head_order", 256'(log_q), 256'(mk(10 * rep + i)));
        tick();
      end
      idle();
      #1 check("dual_drained", 256'(queue_empty), 256'(1));
    end

    // Near full: count 7, both ports valid, only port 0 accepted.
    for (int i = 0; i < 3; i++) begin
      set_in(2'b11, mk(20 + 2 * i), mk(21 + 2 * i), 1'b0, 1'b0);
      tick();
    end
    set_in(2'b01, mk(26), '0, 1'b0, 1'b0);
    tick();
    set_in(2'b11, mk(27), mk(28), 1'b0, 1'b0);
    #1 check("near_ready", 256'(push_ready), 256'(2'b01));
    tick(); idle();
    #1;
    check("near_count", 256'(count), 256'(8));
    check("near_full",  256'(queue_full), 256'(1));

    // Full: pop with push; push refused.
    set_in(2'b01, mk(29), '0, 1'b1, 1'b0);
    #1 check("fullpop_ready", 256'(push_ready), 256'(2'b00));
    tick(); idle();
    #1;
    check("fullpop_count", 256'(count), 256'(7));
    check("fullpop_head",  256'(log_q), 256'(mk(21)));
    // count 7: pop plus one push, both applied.
    set_in(2'b01, mk(30), '0, 1'b1, 1'b0);
    tick(); idle();
    #1;
    check("poppush_count", 256'(count), 256'(7));
    check("poppush_head",  256'(log_q), 256'(mk(22)));
    for (int i = 0; i < 7; i++) begin
      set_in(2'b00, '0, '0, 1'b1, 1'b0);
      #1 check("poppush_drain", 256'(log_q), (i < 6) ? 256'(mk(22 + i)) : 256'(mk(30)));
      tick();
    end
    idle();

    // Flush at count 5 with pop and both pushes present.
    set_in(2'b11, mk(40), mk(41), 1'b0, 1'b0); tick();
    set_in(2'b11, mk(42), mk(43), 1'b0, 1'b0); tick();
    set_in(2'b01, mk(44), '0, 1'b0, 1'b0); tick();
    set_in(2'b11, mk(45), mk(46), 1'b1, 1'b1);
    #1 check("flush_ready_pre", 256'(push_ready), 256'(2'b11));
    tick(); idle();
    #1;
    check("flush_count", 256'(count), 256'(0));
    check("flush_empty", 256'(queue_empty), 256'(1));
    check("flush_hw",    256'(high_water), 256'(0));
    set_in(2'b00, '0, '0, 1'b1, 1'b0);
    tick(); idle();
    #1 check("empty_pop_count", 256'(count), 256'(0));

    // Head stability while three more records arrive behind it.
    set_in(2'b01, mk(50), '0, 1'b0, 1'b0);
    tick(); idle();
    #1 held = log_q;
    check("stable_first", 256'(held), 256'(mk(50)));
    for (int i = 0; i < 10; i++) begin
      if (i < 3) set_in(2'b01, mk(51 + i), '0, 1'b0, 1'b0);
      else       idle();
      tick();
      #1 check("stable_head", 256'(log_q), 256'(mk(50)));
    end
    check("stable_count", 256'(count), 256'(4));
    check("stats_hw", 256'(high_water), STATS ? 256'(4) : 256'(0));

    // Asynchronous reset between clock edges.
    #3 rst = 1'b1;
    #1;
    check("async_count", 256'(count), 256'(0));
    check("async_empty", 256'(queue_empty), 256'(1));
    check("async_log",   256'(log_q), 256'(0));
    check("async_ready", 256'(push_ready), 256'(2'b11));
    check("async_hw",    256'(high_water), 256'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
